// File: rtl/adc_frame_collector.sv
// adc_frame_collector: aligns per-lane ADC sample words into one coherent frame
// per conversion. It tags each frame with a sequence number, reports lane
// skew/overrun, and keeps sticky per-channel out-of-window flags.
module adc_frame_collector #(
    parameter int          N_ADC         = 2,
    parameter int          CH_PER_ADC    = 8,
    parameter int          DW            = 12,
    parameter logic [11:0] SIGNAL_LEVEL1 = 12'h7B7,
    parameter logic [11:0] SIGNAL_LEVEL2 = 12'h81B,
    parameter int          SKEW_TMO      = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [N_ADC-1:0]                 adc_en,
    input  logic [N_ADC-1:0]                 des_run,
    input  logic [N_ADC-1:0]                 s_valid,
    input  logic [N_ADC*CH_PER_ADC*DW-1:0]   s_data,
    input  logic                             check_en,
    input  logic                             status_clr,
    output logic                             frame_valid,
    output logic [N_ADC*CH_PER_ADC*DW-1:0]   frame_data,
    output logic [15:0]                      frame_seq,
    output logic                             skew_err,
    output logic [N_ADC*CH_PER_ADC-1:0]      oow_flag,
    output logic                             DES_run
);

    localparam int NCH = N_ADC * CH_PER_ADC;
    localparam int LW  = CH_PER_ADC * DW;
    localparam int FW  = NCH * DW;
    localparam int CW  = (DW > 12) ? DW : 12;
    // The timer counts down to zero on the last permitted cycle, so it is
    // loaded one short of SKEW_TMO.
    localparam logic [7:0] TMO_LOAD = 8'(SKEW_TMO - 1);

    typedef enum logic [1:0] {
        S_HALT,
        S_IDLE,
        S_COLLECT
    } state_t;

    state_t             state_q, state_d;
    logic [N_ADC-1:0]   held_q, held_d;
    logic [FW-1:0]      hold_q, hold_d;
    logic [7:0]         timer_q, timer_d;
    logic [N_ADC-1:0]   en_prev_q;
    logic               des_run_q;
    logic               frame_valid_q;
    logic [FW-1:0]      frame_data_q;
    logic [15:0]        frame_seq_q;
    logic               skew_q, skew_d;
    logic [NCH-1:0]     oow_q, oow_d;

    logic [N_ADC-1:0]   vld;
    logic [N_ADC-1:0]   cap_mask;
    logic               halt_cond;
    logic               en_change;
    logic               complete;
    logic               overrun;
    logic               emit;
    logic [FW-1:0]      frame_d;
    logic [NCH-1:0]     oow_set;

    assign vld       = s_valid & adc_en;
    assign halt_cond = (adc_en == '0) || ((des_run & adc_en) != '0);
    assign en_change = (adc_en != en_prev_q);
    assign complete  = (((held_q | vld) & adc_en) == adc_en);
    assign overrun   = ((vld & held_q) != '0);

    // Outgoing frame: fresh words for lanes completing now, held words otherwise.
    for (genvar k = 0; k < N_ADC; k++) begin : g_lane
        assign frame_d[k*LW +: LW] = adc_en[k]
                                   ? (vld[k] ? s_data[k*LW +: LW] : hold_q[k*LW +: LW])
                                   : '0;
    end

    // Window test per channel on the frame being emitted, unsigned and zero-extended.
    for (genvar i = 0; i < NCH; i++) begin : g_chan
        logic [CW-1:0] smp;
        assign smp        = CW'(frame_d[i*DW +: DW]);
        assign oow_set[i] = emit && check_en && adc_en[i / CH_PER_ADC] &&
                            ((smp < CW'(SIGNAL_LEVEL1)) || (smp > CW'(SIGNAL_LEVEL2)));
    end

    // Next-state logic: halt and enable changes override the collection FSM.
    always_comb begin
        state_d  = state_q;
        held_d   = held_q;
        timer_d  = timer_q;
        cap_mask = '0;
        emit     = 1'b0;
        skew_d   = 1'b0;
        if (halt_cond) begin
            state_d = S_HALT;
            held_d  = '0;
        end else if (en_change) begin
            state_d = S_IDLE;
            held_d  = '0;
        end else begin
            unique case (state_q)
                S_HALT: begin
                    state_d = S_IDLE;
                end
                S_IDLE: begin
                    if (vld != '0) begin
                        if (complete) begin
                            emit = 1'b1;
                        end else begin
                            cap_mask = vld;
                            held_d   = vld;
                            timer_d  = TMO_LOAD;
                            state_d  = S_COLLECT;
                        end
                    end
                end
                S_COLLECT: begin
                    if (overrun) begin
                        skew_d   = 1'b1;
                        cap_mask = vld & held_q;
                        held_d   = vld & held_q;
                        timer_d  = TMO_LOAD;
                    end else if (complete) begin
                        emit    = 1'b1;
                        held_d  = '0;
                        state_d = S_IDLE;
                    end else if (timer_q == 8'd0) begin
                        skew_d  = 1'b1;
                        held_d  = '0;
                        state_d = S_IDLE;
                    end else begin
                        cap_mask = vld;
                        held_d   = held_q | vld;
                        timer_d  = timer_q - 8'd1;
                    end
                end
                default: begin
                    state_d = S_HALT;
                    held_d  = '0;
                end
            endcase
        end
    end

    // Holding registers take the incoming words of the lanes being captured.
    always_comb begin
        hold_d = hold_q;
        for (int k = 0; k < N_ADC; k++) begin
            if (cap_mask[k]) begin
                hold_d[k*LW +: LW] = s_data[k*LW +: LW];
            end
        end
    end

    // Sticky window flags: a new violation wins over a simultaneous clear.
    always_comb begin
        oow_d = (status_clr ? '0 : oow_q) | oow_set;
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_HALT;
            held_q        <= '0;
            hold_q        <= '0;
            timer_q       <= '0;
            en_prev_q     <= '0;
            des_run_q     <= 1'b0;
            frame_valid_q <= 1'b0;
            frame_data_q  <= '0;
            frame_seq_q   <= '0;
            skew_q        <= 1'b0;
            oow_q         <= '0;
        end else begin
            state_q       <= state_d;
            held_q        <= held_d;
            hold_q        <= hold_d;
            timer_q       <= timer_d;
            en_prev_q     <= adc_en;
            des_run_q     <= |(des_run & adc_en);
            frame_valid_q <= emit;
            skew_q        <= skew_d;
            oow_q         <= oow_d;
            if (emit) begin
                frame_data_q <= frame_d;
                frame_seq_q  <= frame_seq_q + 16'd1;
            end
        end
    end

    assign frame_valid = frame_valid_q;
    assign frame_data  = frame_data_q;
    assign frame_seq   = frame_seq_q;
    assign skew_err    = skew_q;
    assign oow_flag    = oow_q;
    assign DES_run     = des_run_q;

endmodule

// File: tb/tb_adc_frame_collector.sv
// Scoreboard bench for adc_frame_collector: stimulus queues expected frames and
// skew pulses with their arrival cycle; a monitor pops and compares them.
module tb_adc_frame_collector;

    localparam int N_ADC = 2;
    localparam int CHP   = 8;
    localparam int DW    = 12;
    localparam int NCH   = N_ADC * CHP;
    localparam int FW    = NCH * DW;

    typedef struct {
        int              cyc;
        logic [FW-1:0]   data;
        logic [15:0]     seq;
    } frame_t;

    logic              clk;
    logic              rst;
    logic [N_ADC-1:0]  adc_en;
    logic [N_ADC-1:0]  des_run;
    logic [N_ADC-1:0]  s_valid;
    logic [FW-1:0]     s_data;
    logic              check_en;
    logic              status_clr;
    logic              frame_valid;
    logic [FW-1:0]     frame_data;
    logic [15:0]       frame_seq;
    logic              skew_err;
    logic [NCH-1:0]    oow_flag;
    logic              DES_run;

    frame_t            frameQ[$];
    int                skewQ[$];
    int                cyc;
    int                nVec;
    int                nFail;
    logic [15:0]       expSeq;

    adc_frame_collector #(
        .N_ADC(N_ADC), .CH_PER_ADC(CHP), .DW(DW),
        .SIGNAL_LEVEL1(12'h7B7), .SIGNAL_LEVEL2(12'h81B), .SKEW_TMO(8)
    ) dut (
        .clk(clk), .rst(rst), .adc_en(adc_en), .des_run(des_run),
        .s_valid(s_valid), .s_data(s_data), .check_en(check_en),
        .status_clr(status_clr), .frame_valid(frame_valid),
        .frame_data(frame_data), .frame_seq(frame_seq), .skew_err(skew_err),
        .oow_flag(oow_flag), .DES_run(DES_run)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter used to timestamp expectations.
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares every frame and skew pulse against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (frameQ.size() > 0 && frameQ[0].cyc < cyc) begin
                nVec++;
                nFail++;
                $display("[TB] FAIL frame_missing: got none at cycle %0d, expected frame seq %0h", frameQ[0].cyc, frameQ[0].seq);
                void'(frameQ.pop_front());
            end
            if (frame_valid) begin
                nVec++;
                if (frameQ.size() == 0) begin
                    nFail++;
                    $display("[TB] FAIL frame_unexpected: got seq %0h at cycle %0d, expected no frame", frame_seq, cyc);
                end else begin
                    frame_t e;
                    e = frameQ.pop_front();
                    if (e.cyc != cyc || e.data !== frame_data || e.seq !== frame_seq) begin
                        nFail++;
                        $display("[TB] FAIL frame: got cyc %0d seq %h data %h, expected cyc %0d seq %h data %h",
                                 cyc, frame_seq, frame_data, e.cyc, e.seq, e.data);
                    end
                end
            end
            if (skewQ.size() > 0 && skewQ[0] < cyc) begin
                nVec++;
                nFail++;
                $display("[TB] FAIL skew_missing: got none, expected pulse at cycle %0d", skewQ[0]);
                void'(skewQ.pop_front());
            end
            if (skew_err) begin
                nVec++;
                if (skewQ.size() == 0) begin
                    nFail++;
                    $display("[TB] FAIL skew_unexpected: got pulse at cycle %0d, expected none", cyc);
                end else begin
                    int ec;
                    ec = skewQ.pop_front();
                    if (ec != cyc) begin
                        nFail++;
                        $display("[TB] FAIL skew_cycle: got cycle %0d, expected cycle %0d", cyc, ec);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic checkOutput(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        nVec++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive a one-cycle strobe with the given lane mask and data.
    task automatic applyStimulus(input logic [N_ADC-1:0] v, input logic [FW-1:0] d);
        s_valid = v;
        s_data  = d;
        tick();
        s_valid = '0;
    endtask

    task automatic pushFrame(input logic [FW-1:0] d);
        frame_t e;
        expSeq = expSeq + 16'd1;
        e.cyc  = cyc + 1;
        e.data = d;
        e.seq  = expSeq;
        frameQ.push_back(e);
    endtask

    function automatic logic [FW-1:0] mk(input logic [11:0] base);
        logic [FW-1:0] f;
        for (int i = 0; i < NCH; i++) f[i*DW +: DW] = base + 12'(i);
        return f;
    endfunction

    function automatic logic [FW-1:0] merge(input logic [FW-1:0] lo, input logic [FW-1:0] hi);
        logic [FW-1:0] m;
        m = hi;
        m[FW/2-1:0] = lo[FW/2-1:0];
        return m;
    endfunction

    function automatic logic [FW-1:0] setCh(input logic [FW-1:0] f, input int ch, input logic [11:0] v);
        logic [FW-1:0] r;
        r = f;
        r[ch*DW +: DW] = v;
        return r;
    endfunction

    initial begin
        int t0;
        logic [FW-1:0] base;
        logic [FW-1:0] vec;
        cyc = 0; nVec = 0; nFail = 0; expSeq = 16'd0;
        rst = 1'b1; adc_en = 2'b11; des_run = '0; s_valid = '0; s_data = '0;
        check_en = 1'b0; status_clr = 1'b0;
        repeat (3) tick();

        checkOutput("rst_frame_valid", FW'(frame_valid), FW'(1'b0));
        checkOutput("rst_frame_data", frame_data, '0);
        checkOutput("rst_frame_seq", FW'(frame_seq), FW'(16'h0000));
        checkOutput("rst_skew_err", FW'(skew_err), FW'(1'b0));
        checkOutput("rst_oow_flag", FW'(oow_flag), FW'(16'h0000));
        checkOutput("rst_DES_run", FW'(DES_run), FW'(1'b0));

        rst = 1'b0;
        repeat (3) tick();

        // Both lanes together: frame next cycle, seq 1.
        pushFrame(mk(12'h7C0));
        applyStimulus(2'b11, mk(12'h7C0));

        // Lane0 at t, lane1 at t+3: frame at t+4.
        t0 = cyc;
        applyStimulus(2'b01, mk(12'h100));
        repeat (2) tick();
        pushFrame(merge(mk(12'h100), mk(12'h200)));
        applyStimulus(2'b10, mk(12'h200));
        repeat (2) tick();

        // Lane1 silent: skew pulse at t+9, then a paired frame continues the sequence.
        t0 = cyc;
        skewQ.push_back(t0 + 9);
        applyStimulus(2'b01, mk(12'h300));
        repeat (10) tick();
        pushFrame(mk(12'h400));
        applyStimulus(2'b11, mk(12'h400));
        tick();

        // Lane1 on the last permitted cycle (t+8) still completes.
        t0 = cyc;
        applyStimulus(2'b01, mk(12'h500));
        repeat (7) tick();
        pushFrame(merge(mk(12'h500), mk(12'h600)));
        applyStimulus(2'b10, mk(12'h600));
        repeat (2) tick();

        // Overrun: lane0 twice, skew on the second; frame carries the second word.
        t0 = cyc;
        applyStimulus(2'b01, mk(12'h700));
        tick();
        skewQ.push_back(t0 + 3);
        applyStimulus(2'b01, mk(12'h800));
        tick();
        pushFrame(merge(mk(12'h800), mk(12'h900)));
        applyStimulus(2'b10, mk(12'h900));
        repeat (2) tick();

        // Window check: ch3 and ch7 below, ch8 above; ch5 and ch6 on the bounds.
        check_en = 1'b1;
        for (int i = 0; i < NCH; i++) base[i*DW +: DW] = 12'h7C0;
        vec = setCh(base, 3, 12'h700);
        vec = setCh(vec, 5, 12'h81B);
        vec = setCh(vec, 6, 12'h7B7);
        vec = setCh(vec, 7, 12'h7B6);
        vec = setCh(vec, 8, 12'h81C);
        pushFrame(vec);
        applyStimulus(2'b11, vec);
        checkOutput("oow_after_frame", FW'(oow_flag), FW'(16'h0188));
        status_clr = 1'b1;
        tick();
        status_clr = 1'b0;
        checkOutput("oow_after_clear", FW'(oow_flag), FW'(16'h0000));
        vec = setCh(base, 3, 12'h700);
        status_clr = 1'b1;
        pushFrame(vec);
        applyStimulus(2'b11, vec);
        status_clr = 1'b0;
        checkOutput("oow_clear_vs_set", FW'(oow_flag), FW'(16'h0008));
        check_en = 1'b0;
        tick();

        // des_run mid-collect: holds dropped, no frame, no skew.
        applyStimulus(2'b01, mk(12'hA00));
        des_run = 2'b10;
        tick();
        checkOutput("DES_run_high", FW'(DES_run), FW'(1'b1));
        applyStimulus(2'b10, mk(12'hB00));
        repeat (2) tick();
        des_run = 2'b00;
        tick();
        checkOutput("DES_run_low", FW'(DES_run), FW'(1'b0));
        repeat (12) tick();
        pushFrame(mk(12'hC00));
        applyStimulus(2'b11, mk(12'hC00));
        tick();

        // Back-to-back frames until the sequence number wraps to zero.
        for (int i = 0; i < 65528; i++) begin
            vec = mk(12'(i));
            pushFrame(vec);
            s_valid = 2'b11;
            s_data  = vec;
            tick();
        end
        s_valid = '0;
        checkOutput("seq_wrap", FW'(frame_seq), FW'(16'h0000));
        tick();
        pushFrame(mk(12'hD00));
        applyStimulus(2'b11, mk(12'hD00));
        tick();
        checkOutput("seq_after_wrap", FW'(frame_seq), FW'(16'h0001));

        // Reset mid-collect clears every output at once.
        applyStimulus(2'b01, mk(12'hE00));
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_frame_valid", FW'(frame_valid), FW'(1'b0));
        checkOutput("mid_rst_frame_data", frame_data, '0);
        checkOutput("mid_rst_frame_seq", FW'(frame_seq), FW'(16'h0000));
        checkOutput("mid_rst_skew_err", FW'(skew_err), FW'(1'b0));
        checkOutput("mid_rst_oow_flag", FW'(oow_flag), FW'(16'h0000));
        checkOutput("mid_rst_DES_run", FW'(DES_run), FW'(1'b0));
        repeat (2) tick();

        checkOutput("frames_left", FW'(frameQ.size()), FW'(0));
        checkOutput("skews_left", FW'(skewQ.size()), FW'(0));

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule
